parallel_serial_tx: RTL

Parametrised parallel-to-serial transmitter for the FPGA exercise datapath. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, LSB- or MSB-first, with frame markers. Supports back-to-back frames with no idle gap. Sits between a word-producing block and a single-wire serial sink.

---
 rtl/parallel_serial_pkg.sv | 15 +
 rtl/ps_bit_counter.sv | 44 ++++
 rtl/parallel_serial_tx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/parallel_serial_pkg.sv
// rtl/parallel_serial_pkg.sv - shared types and limits for the parallel-to-serial transmitter
// Contents: state_t (IDLE, SHIFT, PARITY) and the legal WIDTH bounds.
// Optional feature macro used by the importing files: PAR_SER_PARITY_EN.
package parallel_serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/ps_bit_counter.sv
// rtl/ps_bit_counter.sv - frame bit counter with terminal-count flag and synchronous restart
// Ports:
//   clk      in   rising-edge clock
//   clr_n    in   asynchronous active-low reset
//   en       in   advance the count (holds at WIDTH-1, never wraps by itself)
//   restart  in   synchronous return to 0, takes priority over en
//   cnt      out  current bit index, $clog2(WIDTH) bits
//   tc       out  cnt == WIDTH-1
module ps_bit_counter #(
  parameter int WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     en,
  input  logic                     restart,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     tc
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc  = (cnt_q == CW'(WIDTH - 1));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/parallel_serial_tx.sv
// rtl/parallel_serial_tx.sv - parallel-to-serial transmitter with valid/ready input and frame markers
// Optional feature macro: PAR_SER_PARITY_EN (appends an even-parity bit to every frame).
// Parameters: WIDTH (2..32) word width; MSB_FIRST (0: bit 0 first, 1: bit WIDTH-1 first).
// Ports:
//   clk          in   rising-edge clock
//   clr_n        in   asynchronous active-low reset
//   in_valid     in   producer has a word on in_data
//   in_data      in   parallel word, sampled only on acceptance
//   in_ready     out  word can be accepted this cycle (combinational)
//   out          out  serial data bit (0 when out_valid is low)
//   out_valid    out  out carries a frame bit
//   frame_start  out  first bit of a frame
//   frame_end    out  last bit of a frame (parity bit when enabled)
//   busy         out  a frame is being transmitted
module parallel_serial_tx #(
  parameter int WIDTH     = 6,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  import parallel_serial_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;

  logic [CW-1:0]    cnt;
  logic             tc;
  logic             accept;
  logic             last_cycle;

  // First bit of a newly accepted word and the remainder left in the shift
  // register; the register always presents its next bit at the exit end.
  logic             load_bit, next_bit;
  logic [WIDTH-1:0] load_rest, next_rest;

`ifdef PAR_SER_PARITY_EN
  logic par_q, par_d;
  assign last_cycle = (state_q == PARITY);
`else
  assign last_cycle = (state_q == SHIFT) && tc;
`endif

  assign in_ready = clr_n && ((state_q == IDLE) || last_cycle);
  assign accept   = in_valid && in_ready;

  // cnt tracks the bit currently on out; leaving SHIFT returns it to 0 so
  // that it only wraps on a frame boundary.
  ps_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk     (clk),
    .clr_n   (clr_n),
    .en      (state_q == SHIFT),
    .restart (accept || ((state_q == SHIFT) && tc)),
    .cnt     (cnt),
    .tc      (tc)
  );

  always_comb begin
    if (MSB_FIRST) begin
      load_bit  = in_data[WIDTH-1];
      load_rest = in_data << 1;
      next_bit  = shreg_q[WIDTH-1];
      next_rest = shreg_q << 1;
    end else begin
      load_bit  = in_data[0];
      load_rest = in_data >> 1;
      next_bit  = shreg_q[0];
      next_rest = shreg_q >> 1;
    end
  end

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    out_d         = 1'b0;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
`ifdef PAR_SER_PARITY_EN
    par_d         = par_q;
`endif

    case (state_q)
      SHIFT: begin
        if (!tc) begin
          out_d       = next_bit;
          shreg_d     = next_rest;
          out_valid_d = 1'b1;
`ifndef PAR_SER_PARITY_EN
          // The bit being loaded now is the last data bit of the frame.
          frame_end_d = (cnt == CW'(WIDTH - 2));
`endif
        end else begin
`ifdef PAR_SER_PARITY_EN
          state_d     = PARITY;
          out_d       = par_q;
          out_valid_d = 1'b1;
          frame_end_d = 1'b1;
`else
          state_d     = IDLE;
`endif
        end
      end
`ifdef PAR_SER_PARITY_EN
      PARITY: state_d = IDLE;
`endif
      default: ;
    endcase

    // Acceptance overrides the above; it only happens in IDLE or in the
    // final cycle of a frame, giving gap-free back-to-back frames.
    if (accept) begin
      state_d       = SHIFT;
      shreg_d       = load_rest;
      out_d         = load_bit;
      out_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      frame_end_d   = 1'b0;
`ifdef PAR_SER_PARITY_EN
      par_d         = ^in_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      out_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
`ifdef PAR_SER_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
`ifdef PAR_SER_PARITY_EN
      par_q         <= par_d;
`endif
    end
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign busy        = (state_q != IDLE);

endmodule
